// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer:
// op encodings, FSM states, default latencies and counter width.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Latencies must fit in the countdown (<= 15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mdu_sequencer_if.sv
// E/D-stage MDU bus: E-stage command and operands, D-stage op,
// busy/stall/read-back and architectural HI/LO. slave = sequencer.
interface mdu_sequencer_if;

    logic [3:0]  E_MDU_Ctr;
    logic        E_start;
    logic [31:0] E_RS;
    logic [31:0] E_RT;
    logic [3:0]  D_MDU_Ctr;
    logic        E_busy;
    logic [31:0] E_MDU_Out;
    logic        D_MDU_Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output E_MDU_Ctr, E_start, E_RS, E_RT, D_MDU_Ctr,
        input  E_busy, E_MDU_Out, D_MDU_Stall, HI, LO
    );

    modport slave (
        input  E_MDU_Ctr, E_start, E_RS, E_RT, D_MDU_Ctr,
        output E_busy, E_MDU_Out, D_MDU_Stall, HI, LO
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide: op, a, b -> {hi,lo} plus div_by_zero.
// Ports: op (mdu_op_e code), a, b in; res {hi,lo}, div_by_zero out.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_by_zero
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        b_safe;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic               is_div;

    assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign div_by_zero = is_div && (b == 32'd0);

    // Divisor forced to 1 on zero so the dividers never see 0;
    // the sequencer discards that result anyway.
    assign b_safe = (b == 32'd0) ? 32'd1 : b;

    assign sa = $signed(a);
    assign sb = $signed(b_safe);

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed / and % truncate toward zero; remainder follows dividend.
    assign q_s = sa / sb;
    assign r_s = sa % sb;
    assign q_u = a / b_safe;
    assign r_u = a % b_safe;

    always_comb begin
        res = '0;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   res = {r_s, q_s};
            MDU_DIVU:  res = {r_u, q_u};
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage MDU scheduler: busy countdown, pending result, HI/LO, stall.
// Ports: clk, reset (async active-low), bus (mdu_sequencer_if.slave).
// Option MDU_DIV_ZERO_FAST_EN: divide by zero busies for one cycle.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mdu_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_wr_q, pend_wr_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      res;
    logic             div_zero;
    logic             is_arith;
    logic             is_mult;
    logic [CNT_W-1:0] load_cnt;

    mdu_arith u_arith (
        .op          (bus.E_MDU_Ctr),
        .a           (bus.E_RS),
        .b           (bus.E_RT),
        .res         (res),
        .div_by_zero (div_zero)
    );

    assign is_mult  = (bus.E_MDU_Ctr == MDU_MULT) ||
                      (bus.E_MDU_Ctr == MDU_MULTU);
    assign is_arith = is_mult ||
                      (bus.E_MDU_Ctr == MDU_DIV) ||
                      (bus.E_MDU_Ctr == MDU_DIVU);

    always_comb begin
        load_cnt = CNT_DIV;
        if (is_mult) begin
            load_cnt = CNT_MULT;
        end
`ifdef MDU_DIV_ZERO_FAST_EN
        else if (div_zero) begin
            load_cnt = CNT_ONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.E_start && is_arith) begin
                    pend_d    = res;
                    // A zero divisor still runs the countdown but
                    // must leave HI/LO untouched when it ends.
                    pend_wr_d = !div_zero;
                    cnt_d     = load_cnt;
                    state_d   = BUSY;
                end else if (bus.E_MDU_Ctr == MDU_MTHI) begin
                    hi_d = bus.E_RS;
                end else if (bus.E_MDU_Ctr == MDU_MTLO) begin
                    lo_d = bus.E_RS;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.E_MDU_Out = '0;
        if (bus.E_MDU_Ctr == MDU_MFHI) begin
            bus.E_MDU_Out = hi_q;
        end else if (bus.E_MDU_Ctr == MDU_MFLO) begin
            bus.E_MDU_Out = lo_q;
        end
    end

    assign bus.E_busy      = (state_q == BUSY);
    assign bus.D_MDU_Stall = (bus.D_MDU_Ctr != 4'd0) &&
                             (bus.E_start || bus.E_busy);
    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;

endmodule
